// File: rtl/aes_subbytes_col_sequencer_if.sv
// Bus bundle for aes_subbytes_col_sequencer: state in/out handshakes, busy, and the shared SubBytes column path.
interface aes_subbytes_col_sequencer_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         enc_dec_in;
    logic [31:0]  sb_word_out;
    logic         sb_enc_dec;
    logic [31:0]  sb_word_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;

    modport master (
        output in_valid, state_in, enc_dec_in, sb_word_in, out_ready,
        input  in_ready, sb_word_out, sb_enc_dec, out_valid, state_out, busy
    );

    modport slave (
        input  in_valid, state_in, enc_dec_in, sb_word_in, out_ready,
        output in_ready, sb_word_out, sb_enc_dec, out_valid, state_out, busy
    );
endinterface

// File: rtl/aes_subbytes_col_sequencer.sv
// Streams a 128-bit AES state one column per cycle through the shared SubBytes datapath and collects the result.
// Optional macro AES_SEQ_SHIFTROWS_EN applies ShiftRows/InvShiftRows to state_out; otherwise it is the raw result.
module aes_subbytes_col_sequencer (
    input  logic                           clk,
    input  logic                           rst_n,
    aes_subbytes_col_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] state_reg_q, state_reg_d;
    logic [127:0] result_q, result_d;
    logic         mode_q, mode_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic         busy_q, busy_d;
    logic [31:0]  cur_col;
    logic [127:0] shifted;

    always_comb begin
        case (col_q)
            2'd0:    cur_col = state_reg_q[127:96];
            2'd1:    cur_col = state_reg_q[95:64];
            2'd2:    cur_col = state_reg_q[63:32];
            default: cur_col = state_reg_q[31:0];
        endcase
    end

    always_comb begin
        fsm_d       = fsm_q;
        col_d       = col_q;
        state_reg_d = state_reg_q;
        result_d    = result_q;
        mode_d      = mode_q;
        case (fsm_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_reg_d = bus.state_in;
                    mode_d      = bus.enc_dec_in;
                    col_d       = 2'd0;
                    fsm_d       = SUB;
                end
            end
            SUB: begin
                // sb_word_in is the combinational S-box image of the column presented this cycle
                case (col_q)
                    2'd0:    result_d[127:96] = bus.sb_word_in;
                    2'd1:    result_d[95:64]  = bus.sb_word_in;
                    2'd2:    result_d[63:32]  = bus.sb_word_in;
                    default: result_d[31:0]   = bus.sb_word_in;
                endcase
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    fsm_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
        in_ready_d  = (fsm_d == IDLE);
        out_valid_d = (fsm_d == DONE);
        busy_d      = (fsm_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            col_q       <= 2'd0;
            state_reg_q <= '0;
            result_q    <= '0;
            mode_q      <= 1'b1;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            col_q       <= col_d;
            state_reg_q <= state_reg_d;
            result_q    <= result_d;
            mode_q      <= mode_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

`ifdef AES_SEQ_SHIFTROWS_EN
    // Row r rotates left by r for encrypt, right by r for decrypt
    always_comb begin
        shifted = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (mode_q) begin
                    shifted[127 - 32*c - 8*r -: 8] = result_q[127 - 32*((c + r) % 4) - 8*r -: 8];
                end else begin
                    shifted[127 - 32*c - 8*r -: 8] = result_q[127 - 32*((c + 4 - r) % 4) - 8*r -: 8];
                end
            end
        end
    end
`else
    assign shifted = result_q;
`endif

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.busy        = busy_q;
    assign bus.state_out   = shifted;
    assign bus.sb_word_out = (fsm_q == SUB) ? cur_col : 32'h0;
    assign bus.sb_enc_dec  = mode_q;

endmodule

// File: tb/tb_aes_subbytes_col_sequencer.sv
// Scoreboard bench for aes_subbytes_col_sequencer with a behavioural S-box on the SubBytes return path.
// Expected values follow the AES_SEQ_SHIFTROWS_EN setting of the build.
module tb_aes_subbytes_col_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_subbytes_col_sequencer_if bus_if ();

    aes_subbytes_col_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [0:255][7:0] fwd_tbl;
    logic [7:0]        inv_tbl [256];
    logic [127:0]      exp_q [$];

    typedef struct {
        logic [127:0] s;
        logic         enc;
        logic [127:0] e;
    } vec_t;

    function automatic logic [31:0] sub_word(input logic [31:0] w, input logic enc);
        logic [31:0] r;
        logic [7:0]  b;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            b = w[31 - 8*i -: 8];
            r[31 - 8*i -: 8] = enc ? fwd_tbl[b] : inv_tbl[b];
        end
        return r;
    endfunction

    function automatic logic [127:0] model_state(input logic [127:0] in, input logic enc);
        logic [127:0] s;
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            s[127 - 32*c -: 32] = sub_word(in[127 - 32*c -: 32], enc);
        end
        o = s;
`ifdef AES_SEQ_SHIFTROWS_EN
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (enc) o[127 - 32*c - 8*r -: 8] = s[127 - 32*((c + r) % 4) - 8*r -: 8];
                else     o[127 - 32*c - 8*r -: 8] = s[127 - 32*((c + 4 - r) % 4) - 8*r -: 8];
            end
        end
`endif
        return o;
    endfunction

    function automatic logic [127:0] pop_expected();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    function automatic logic [127:0] rand_state();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    assign bus_if.sb_word_in = sub_word(bus_if.sb_word_out, bus_if.sb_enc_dec);

    task automatic accept_state(input logic [127:0] s, input logic enc, input logic [127:0] e,
                                output time t_acc);
        int n;
        n = 0;
        t_acc = 0;
        @(negedge clk);
        while (bus_if.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept_timeout in_ready=%b required 1", bus_if.in_ready);
            return;
        end
        bus_if.state_in   = s;
        bus_if.enc_dec_in = enc;
        bus_if.in_valid   = 1'b1;
        @(posedge clk);
        t_acc = $time;
        exp_q.push_back(e);
        #1;
        bus_if.in_valid = 1'b0;
    endtask

    task automatic wait_out_valid(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (bus_if.out_valid !== 1'b1 && cycles < 20);
    endtask

    task automatic complete_handshake();
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n             = 1'b0;
        bus_if.in_valid   = 1'b0;
        bus_if.out_ready  = 1'b0;
        bus_if.state_in   = '0;
        bus_if.enc_dec_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (bus_if.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready got %b want 1", bus_if.in_ready); end
        vectors++; if (bus_if.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid got %b want 0", bus_if.out_valid); end
        vectors++; if (bus_if.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", bus_if.busy); end
        vectors++; if (bus_if.state_out !== 128'h0) begin miscompares++; $display("[TB] FAIL reset_state_out got %h want 0", bus_if.state_out); end
        vectors++; if (bus_if.sb_word_out !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_sb_word_out got %h want 0", bus_if.sb_word_out); end
        vectors++; if (bus_if.sb_enc_dec !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_sb_enc_dec got %b want 1", bus_if.sb_enc_dec); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        vec_t         v [$];
        logic [127:0] got;
        logic [127:0] want;
        logic [127:0] r;
        int           cyc;
        time          t;
`ifdef AES_SEQ_SHIFTROWS_EN
        v.push_back('{128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b1, 128'hd4bf5d30e0b452aeb84111f11e2798e5});
        v.push_back('{128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 128'h193de3bea0f4e22b9ac68d2ae9f84808});
`else
        v.push_back('{128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b1, 128'hd42711aee0bf98f1b8b45de51e415230});
        v.push_back('{128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 128'h193de3bea0f4e22b9ac68d2ae9f84808});
`endif
        v.push_back('{128'h0, 1'b1, {16{8'h63}}});
        v.push_back('{128'h0, 1'b0, {16{8'h52}}});
        for (int i = 0; i < 2; i++) begin
            r = rand_state();
            v.push_back('{r, i[0], model_state(r, i[0])});
        end
        foreach (v[i]) begin
            accept_state(v[i].s, v[i].enc, v[i].e, t);
            wait_out_valid(cyc);
            vectors++; if (cyc !== 4) begin miscompares++; $display("[TB] FAIL latency_%0d got %0d want 4", i, cyc); end
            got  = bus_if.state_out;
            want = pop_expected();
            vectors++; if (got !== want) begin miscompares++; $display("[TB] FAIL state_out_%0d got %h want %h", i, got, want); end
            vectors++; if (bus_if.busy !== 1'b1 || bus_if.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL done_flags_%0d busy=%b in_ready=%b want 1/0", i, bus_if.busy, bus_if.in_ready); end
            complete_handshake();
            vectors++; if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL release_%0d out_valid=%b in_ready=%b want 0/1", i, bus_if.out_valid, bus_if.in_ready); end
        end
    endtask

    task automatic test_sequence();
        logic [127:0] s;
        logic [127:0] got;
        logic [127:0] want;
        logic [31:0]  col;
        time          t;
        s = rand_state();
        @(negedge clk);
        vectors++; if (bus_if.sb_word_out !== 32'h0) begin miscompares++; $display("[TB] FAIL seq_idle_word got %h want 0", bus_if.sb_word_out); end
        accept_state(s, 1'b0, model_state(s, 1'b0), t);
        for (int k = 0; k < 4; k++) begin
            col = s[127 - 32*k -: 32];
            vectors++; if (bus_if.sb_word_out !== col) begin miscompares++; $display("[TB] FAIL seq_col%0d got %h want %h", k, bus_if.sb_word_out, col); end
            vectors++; if (bus_if.sb_enc_dec !== 1'b0 || bus_if.busy !== 1'b1) begin miscompares++; $display("[TB] FAIL seq_mode%0d enc_dec=%b busy=%b want 0/1", k, bus_if.sb_enc_dec, bus_if.busy); end
            @(posedge clk);
            #1;
        end
        vectors++; if (bus_if.out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL seq_done_valid got %b want 1", bus_if.out_valid); end
        vectors++; if (bus_if.sb_word_out !== 32'h0) begin miscompares++; $display("[TB] FAIL seq_done_word got %h want 0", bus_if.sb_word_out); end
        got  = bus_if.state_out;
        want = pop_expected();
        vectors++; if (got !== want) begin miscompares++; $display("[TB] FAIL seq_state_out got %h want %h", got, want); end
        complete_handshake();
    endtask

    task automatic test_backpressure();
        logic [127:0] s;
        logic [127:0] want;
        int           cyc;
        time          t;
        s = rand_state();
        accept_state(s, 1'b1, model_state(s, 1'b1), t);
        wait_out_valid(cyc);
        vectors++; if (cyc !== 4) begin miscompares++; $display("[TB] FAIL bp_latency got %0d want 4", cyc); end
        want = pop_expected();
        bus_if.in_valid   = 1'b1;
        bus_if.state_in   = ~s;
        bus_if.enc_dec_in = 1'b0;
        for (int k = 0; k < 10; k++) begin
            vectors++; if (bus_if.state_out !== want) begin miscompares++; $display("[TB] FAIL bp_hold%0d got %h want %h", k, bus_if.state_out, want); end
            vectors++; if (bus_if.in_ready !== 1'b0 || bus_if.out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_flags%0d in_ready=%b out_valid=%b want 0/1", k, bus_if.in_ready, bus_if.out_valid); end
            @(posedge clk);
            #1;
        end
        bus_if.in_valid = 1'b0;
        complete_handshake();
        vectors++; if (bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_release in_ready=%b out_valid=%b want 1/0", bus_if.in_ready, bus_if.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] got;
        logic [127:0] want;
        int           cyc;
        time          ta;
        time          tb;
        a = rand_state();
        b = rand_state();
        bus_if.out_ready = 1'b1;
        accept_state(a, 1'b1, model_state(a, 1'b1), ta);
        wait_out_valid(cyc);
        vectors++; if (cyc !== 4) begin miscompares++; $display("[TB] FAIL b2b_latency_a got %0d want 4", cyc); end
        got  = bus_if.state_out;
        want = pop_expected();
        vectors++; if (got !== want) begin miscompares++; $display("[TB] FAIL b2b_state_a got %h want %h", got, want); end
        accept_state(b, 1'b0, model_state(b, 1'b0), tb);
        vectors++; if (tb - ta !== 60) begin miscompares++; $display("[TB] FAIL b2b_interval got %0t want 60", tb - ta); end
        wait_out_valid(cyc);
        got  = bus_if.state_out;
        want = pop_expected();
        vectors++; if (got !== want) begin miscompares++; $display("[TB] FAIL b2b_state_b got %h want %h", got, want); end
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b0;
        vectors++; if (bus_if.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_idle in_ready=%b want 1", bus_if.in_ready); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] s;
        logic [127:0] got;
        logic [127:0] want;
        int           cyc;
        time          t;
        s = rand_state();
        accept_state(s, 1'b0, model_state(s, 1'b0), t);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        vectors++; if (bus_if.sb_word_out !== s[63:32]) begin miscompares++; $display("[TB] FAIL mid_col2 got %h want %h", bus_if.sb_word_out, s[63:32]); end
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        vectors++; if (bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0 || bus_if.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_flags in_ready=%b out_valid=%b busy=%b want 1/0/0", bus_if.in_ready, bus_if.out_valid, bus_if.busy); end
        vectors++; if (bus_if.state_out !== 128'h0 || bus_if.sb_word_out !== 32'h0) begin miscompares++; $display("[TB] FAIL mid_rst_data state_out=%h sb_word_out=%h want 0/0", bus_if.state_out, bus_if.sb_word_out); end
        vectors++; if (bus_if.sb_enc_dec !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_rst_mode got %b want 1", bus_if.sb_enc_dec); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            vectors++; if (bus_if.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_stale%0d out_valid=%b want 0", k, bus_if.out_valid); end
        end
        accept_state(128'h0, 1'b1, {16{8'h63}}, t);
        wait_out_valid(cyc);
        vectors++; if (cyc !== 4) begin miscompares++; $display("[TB] FAIL mid_latency got %0d want 4", cyc); end
        got  = bus_if.state_out;
        want = pop_expected();
        vectors++; if (got !== want) begin miscompares++; $display("[TB] FAIL mid_fresh got %h want %h", got, want); end
        complete_handshake();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        fwd_tbl = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
                   128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
                   128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
                   128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
                   128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
                   128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
                   128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
                   128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        for (int i = 0; i < 256; i++) begin
            inv_tbl[fwd_tbl[i]] = 8'(i);
        end
        test_reset();
        test_vectors();
        test_sequence();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
